// File: rtl/fx2fp_pkg.sv
// Shared float32 constants, packed result type and leading-zero-count width helper
// for the fixed-point to float32 converter.
package fx2fp_pkg;

    localparam int unsigned FP32_EXP_BIAS = 127;
    localparam int unsigned FP32_MAN_W    = 23;
    localparam int unsigned FP32_EXP_W    = 8;

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MAN_W-1:0] man;
    } fp32_t;

    // Bits needed to hold a leading-zero count of 0..w inclusive.
    function automatic int unsigned lz_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/fx2fp_pipe_lzc.sv
// Parametrised leading-zero counter; cnt = W and all_zero = 1 for an all-zero word.
module lzc
    import fx2fp_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0]             in_data,
    output logic [lz_width(W)-1:0]   cnt,
    output logic                     all_zero
);

    localparam int unsigned CW = lz_width(W);

    // Scan upward so the highest set bit is the last one to write cnt.
    always_comb begin
        cnt      = CW'(W);
        all_zero = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            if (in_data[i]) begin
                cnt      = CW'(W - 1 - i);
                all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fx2fp_pipe.sv
// Three-stage fixed-point Q(WIDTH-FRAC_BITS).FRAC_BITS to float32 converter with valid/ready.
// Define FX2FP_RNE_EN for round-to-nearest-even; otherwise the magnitude is truncated.
module fx2fp_pipe
    import fx2fp_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FRAC_BITS = 16,
    parameter int unsigned SIGNED    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data
);

    localparam int unsigned CW         = lz_width(WIDTH);
    localparam int unsigned XW         = WIDTH + FP32_MAN_W + 1;
    localparam int          EXP_OFFSET = int'(FP32_EXP_BIAS) + int'(WIDTH) - 1 - int'(FRAC_BITS);

    logic                  adv_c;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_sign_q,  s1_sign_d;
    logic [WIDTH-1:0]      s1_mag_q,   s1_mag_d;
    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_sign_q,  s2_sign_d;
    logic                  s2_zero_q,  s2_zero_d;
    logic [WIDTH-1:0]      s2_norm_q,  s2_norm_d;
    logic signed [8:0]     s2_exp_q,   s2_exp_d;
    logic                  out_valid_q, out_valid_d;
    fp32_t                 out_data_q,  out_data_d;
    logic [CW-1:0]         lz_cnt_c;
    logic                  lz_zero_c;
    logic [XW-1:0]         ext_c;
    logic [FP32_MAN_W-1:0] man_c;
    logic [FP32_MAN_W-1:0] man_r_c;
    logic                  round_carry_c;
    logic                  unused_top_c;

    // One global advance: the whole pipe moves whenever the output slot frees up.
    assign adv_c     = !out_valid_q || out_ready;
    assign in_ready  = adv_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    lzc #(.W(WIDTH)) u_lzc (
        .in_data  (s1_mag_q),
        .cnt      (lz_cnt_c),
        .all_zero (lz_zero_c)
    );

    // S1: sign and magnitude; the WIDTH-bit negation maps the most-negative value to 2^(WIDTH-1).
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        if (adv_c) begin
            s1_valid_d = in_valid;
            s1_sign_d  = (SIGNED != 0) && in_data[WIDTH-1];
            s1_mag_d   = s1_sign_d ? (~in_data + WIDTH'(1)) : in_data;
        end
    end

    // S2: normalise the leading one into the MSB and form the biased exponent.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_zero_d  = s2_zero_q;
        s2_norm_d  = s2_norm_q;
        s2_exp_d   = s2_exp_q;
        if (adv_c) begin
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_zero_d  = lz_zero_c;
            s2_norm_d  = s1_mag_q << lz_cnt_c;
            s2_exp_d   = 9'(EXP_OFFSET - int'(lz_cnt_c));
        end
    end

    // S3: mantissa below the hidden one; zero padding covers words narrower than 24 bits.
    assign ext_c        = {s2_norm_q, {(FP32_MAN_W + 1){1'b0}}};
    assign man_c        = ext_c[XW-2 -: FP32_MAN_W];
    assign unused_top_c = ^{ext_c[XW-1], s2_exp_q[8]};

`ifdef FX2FP_RNE_EN
    logic guard_c;
    logic sticky_c;
    logic round_up_c;

    assign guard_c    = ext_c[XW-FP32_MAN_W-2];
    assign sticky_c   = |ext_c[XW-FP32_MAN_W-3:0];
    assign round_up_c = guard_c && (sticky_c || man_c[0]);
    assign {round_carry_c, man_r_c} = {1'b0, man_c} + (FP32_MAN_W + 1)'(round_up_c);
`else
    logic unused_lsb_c;

    assign round_carry_c = 1'b0;
    assign man_r_c       = man_c;
    assign unused_lsb_c  = ^ext_c[XW-FP32_MAN_W-2:0];
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (adv_c) begin
            out_valid_d = s2_valid_q;
            if (s2_zero_q) begin
                out_data_d = '0;
            end else begin
                out_data_d.sign = s2_sign_q;
                out_data_d.exp  = s2_exp_q[7:0] + 8'(round_carry_c);
                out_data_d.man  = man_r_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_norm_q   <= '0;
            s2_exp_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_mag_q    <= s1_mag_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_zero_q   <= s2_zero_d;
            s2_norm_q   <= s2_norm_d;
            s2_exp_q    <= s2_exp_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: doc/fx2fp_pipe.md
Name: fx2fp_pipe

Overview:
- Pipelined, parametrised fixed-point to IEEE-754 single-precision converter.
- Supports any signed or unsigned Q(WIDTH-FRAC_BITS).FRAC_BITS input format.
- Handles zero and the most-negative input correctly; rounding is selectable at compile time.
- Sits between fixed-point datapaths and the FPU operand bus, with valid/ready streaming on both sides.

Parameters:
- WIDTH, 32, input word width in bits; legal range 8..64.
- FRAC_BITS, 16, number of fractional bits; legal range 0..WIDTH-1.
- SIGNED, 1, 1 = two's-complement input, 0 = unsigned input.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  converter accepts the input word this cycle
- in_data  in  WIDTH  fixed-point operand
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- out_data  out  32  float32 result {sign, exp[7:0], man[22:0]}

Behaviour:
- Reset: clk and rst_n only; reset is synchronous and active-low. While rst_n=0 at a rising edge:
  - all stage valid bits clear, so out_valid=0;
  - out_data=32'h0.
- Reset mid-operation: in-flight words are discarded, with no partial output.
- Pipeline: 3 stages, latency 3 cycles from the in_valid&&in_ready edge to out_valid, when not stalled.
  - S1: capture the sign (SIGNED ? in_data[WIDTH-1] : 0) and the magnitude. Magnitude is the negation for a negative input, computed in WIDTH-bit unsigned so that the most-negative value yields 2^(WIDTH-1) exactly.
  - S2: leading-zero count lz on the magnitude; left-normalise so the leading 1 sits in the MSB. Compute the biased exponent E = 127 + (WIDTH-1-FRAC_BITS) - lz, 9-bit signed internal.
  - S3: take the 23 bits below the leading 1 as mantissa. Derive guard/sticky bits from the remainder, round, pack.
- Zero magnitude: the result is +0.0 (32'h0) regardless of lz, including an unsigned zero.
- Rounding carry: if rounding overflows the mantissa (all ones + 1), mantissa=0 and E increments.
- Exponent range: E is always within 1..254 for the legal parameter range, so no overflow/denormal path is needed.
- Handshake, global stall:
  - adv = !out_valid || out_ready; in_ready = adv.
  - All stages shift only when adv=1; bubbles propagate as valid=0.
  - Stalled output: out_data/out_valid are held stable while out_valid && !out_ready.
  - No word is dropped or duplicated, and order is preserved.
- Simultaneous events:
  - accept and emit in the same cycle: full throughput of 1 word/cycle;
  - reset overrides the handshake.

Optional Feature:
- Macro FX2FP_RNE_EN.
- Defined: round-to-nearest-even using guard and sticky bits; a tie rounds to the even mantissa LSB.
- Undefined: truncation toward zero of the magnitude. Guard/sticky logic is not instantiated; latency is still 3.

Decomposition:
- Package fx2fp_pkg:
  - constants FP32_EXP_BIAS=127, FP32_MAN_W=23, FP32_EXP_W=8;
  - typedef fp32_t, a packed struct {sign, exp, man};
  - function clog2-based LZ width helper.
- One sub-module, lzc #(.W(WIDTH)): parametrised leading-zero counter with outputs cnt[$clog2(WIDTH+1)-1:0] and all_zero. It is used in S2.

Test Plan (defaults WIDTH=32, FRAC_BITS=16, SIGNED=1):
- 32'h00018000 (1.5) -> 32'h3FC00000.
- 32'hFFFF0000 (-1.0) -> 32'hBF800000.
- 32'h00000000 -> 32'h00000000.
- 32'h80000000 (-32768.0) -> 32'hC7000000.
- 32'h7FFFFFFF:
  - with FX2FP_RNE_EN -> 32'h47000000 (rounding carry bumps the exponent);
  - without FX2FP_RNE_EN -> 32'h46FFFFFF.
- Tie case, 32'h01000001 with FX2FP_RNE_EN -> 32'h43800000 (rounds to even).
- Stall/order: stream 6 back-to-back words, hold out_ready=0 for 5 cycles mid-stream. Required response:
  - all 6 results appear in order;
  - out_data is stable while stalled;
  - in_ready=0 during the stall.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 2 words in flight -> out_valid=0 on the next cycle and no stale result emerges afterwards.
- Unsigned mode (SIGNED=0): 32'hFFFF0000 -> 65535.0 = 32'h477FFF00.
